// File: rtl/alu_share_arb.sv
// alu_share_arb -- time-shares one decoder + ALU between two requesters.
//
// Port 0 is the execute stage and port 1 is an auxiliary requester (CSR or
// debug). At most one operation is granted per cycle. The winner's fields
// drive the shared decoder/ALU. The same-cycle alu_result is captured into
// that port's response register, which drains through its own valid/ready
// handshake.
//
// Optional feature macro: ALU_ARB_RR_EN
//   defined   : round-robin tie-break. The pointer holds the last granted port.
//   undefined : port 0 wins ties. A starvation counter forces port 1 to win
//               once it has been denied STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   req{0,1}_valid / _ready         request handshake (ready = comb grant)
//   req{0,1}_opcode/_funct/_add_rshift_type/_a/_b  operation fields
//   rsp{0,1}_valid / _ready / _data registered response per port
//   alu_opcode/_funct/_add_rshift_type/_a/_b       to shared decoder/ALU
//   alu_result                      combinational ALU result, same cycle
//   grant_id, busy                  granted port / grant-issued flag

// One per-port response register. A grant overwrites the register. A drain
// without a grant clears valid and leaves the data as it was.
module alu_share_rsp_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            grant,
    input  logic            drain,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
        end else if (drain) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

module alu_share_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [6:0]      req0_opcode,
    input  logic [2:0]      req0_funct,
    input  logic            req0_add_rshift_type,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [6:0]      req1_opcode,
    input  logic [2:0]      req1_funct,
    input  logic            req1_add_rshift_type,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,

    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_funct,
    output logic            alu_add_rshift_type,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,

    output logic            grant_id,
    output logic            busy
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct;
        logic            add_rshift_type;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

    alu_req_t [NUM_PORTS-1:0]            req;
    alu_req_t                            alu_sel;
    logic     [NUM_PORTS-1:0]            req_valid;
    logic     [NUM_PORTS-1:0]            rsp_valid;
    logic     [NUM_PORTS-1:0]            rsp_ready;
    logic     [NUM_PORTS-1:0][XLEN-1:0]  rsp_data;
    logic     [NUM_PORTS-1:0]            elig;
    logic     [NUM_PORTS-1:0]            grant;
    logic                                tie;
    logic                                tie_win;
    logic                                win_id;

    assign req[0]    = {req0_opcode, req0_funct, req0_add_rshift_type, req0_a, req0_b};
    assign req[1]    = {req1_opcode, req1_funct, req1_add_rshift_type, req1_a, req1_b};
    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A full response register that is not draining blocks only its own
    // port. The other port keeps using the ALU.
    assign elig = req_valid & (~rsp_valid | rsp_ready);
    assign tie  = &elig;

`ifdef ALU_ARB_RR_EN
    // The pointer holds the last granted port. The other port wins a tie.
    // Reset to 1 so that port 0 takes the first tie.
    logic rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rr_ptr <= 1'b1;
        else if (|elig) rr_ptr <= win_id;
    end

    assign tie_win = ~rr_ptr;
`else
    // Counts consecutive cycles in which port 1 was eligible but lost. The
    // counter clears whenever port 1 wins or drops eligibility, so it never
    // goes above STARVE_LIMIT.
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    starve_cnt <= '0;
        else if (!elig[1] || grant[1]) starve_cnt <= '0;
        else                          starve_cnt <= starve_cnt + CNT_W'(1);
    end

    assign tie_win = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif

    // Without a tie, win_id is simply whether port 1 is eligible. That
    // also gives grant_id = 0 when the arbiter is idle.
    always_comb begin
        win_id  = tie ? tie_win : elig[1];
        grant   = '0;
        alu_sel = '0;
        if (|elig) begin
            grant[win_id] = 1'b1;
            alu_sel       = req[win_id];
        end
    end

    assign req0_ready          = grant[0];
    assign req1_ready          = grant[1];
    assign grant_id            = win_id;
    assign busy                = |elig;

    // When idle the ALU drive is all zero, so opcode 0 selects the
    // decoder's default.
    assign alu_opcode          = alu_sel.opcode;
    assign alu_funct           = alu_sel.funct;
    assign alu_add_rshift_type = alu_sel.add_rshift_type;
    assign alu_a               = alu_sel.a;
    assign alu_b               = alu_sel.b;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
        alu_share_rsp_reg #(.XLEN(XLEN)) u_rsp (
            .clk        (clk),
            .reset      (reset),
            .grant      (grant[i]),
            .drain      (rsp_ready[i]),
            .alu_result (alu_result),
            .rsp_valid  (rsp_valid[i]),
            .rsp_data   (rsp_data[i])
        );
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb. A golden RV32 integer ALU model drives
// alu_result from the DUT's alu_* outputs. Expected values are hand-computed.
module tb_alu_share_arb;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready, req0_add_rshift_type;
    logic [6:0]      req0_opcode;
    logic [2:0]      req0_funct;
    logic [XLEN-1:0] req0_a, req0_b;
    logic            req1_valid, req1_ready, req1_add_rshift_type;
    logic [6:0]      req1_opcode;
    logic [2:0]      req1_funct;
    logic [XLEN-1:0] req1_a, req1_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp0_data, rsp1_data;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_funct;
    logic            alu_add_rshift_type;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            grant_id, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct(req0_funct), .req0_add_rshift_type(req0_add_rshift_type),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct(req1_funct), .req1_add_rshift_type(req1_add_rshift_type),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct),
        .alu_add_rshift_type(alu_add_rshift_type),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [31:0] golden(input logic [6:0] op, input logic [2:0] f,
                                           input logic t, input logic [31:0] a,
                                           input logic [31:0] b);
        logic rtype, itype;
        rtype = (op == 7'b0110011);
        itype = (op == 7'b0010011);
        if (!rtype && !itype) return 32'h0;
        case (f)
            3'd0:    return (rtype && t) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return t ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = golden(alu_opcode, alu_funct, alu_add_rshift_type, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [6:0] op, input logic [2:0] f,
                            input logic t, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_opcode = op; req0_funct = f;
        req0_add_rshift_type = t; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic v, input logic [6:0] op, input logic [2:0] f,
                            input logic t, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_opcode = op; req1_funct = f;
        req1_add_rshift_type = t; req1_a = a; req1_b = b;
    endtask

    initial begin
        int exp_g;
        int prev_g;

        reset = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req0(0, 7'h00, 3'd0, 0, 0, 0);
        set_req1(0, 7'h00, 3'd0, 0, 0, 0);
        tick(); tick();

        // reset state and idle drive
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
        chk("rst_rsp0_data",  rsp0_data, 0);
        chk("rst_rsp1_data",  rsp1_data, 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_grant_id",   32'(grant_id), 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        reset = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // single op on port 0: SUB 10 - 3
        set_req0(1, 7'b0110011, 3'b000, 1, 10, 3);
        #1;
        chk("op0_req0_ready", 32'(req0_ready), 1);
        chk("op0_req1_ready", 32'(req1_ready), 0);
        chk("op0_grant_id",   32'(grant_id), 0);
        chk("op0_busy",       32'(busy), 1);
        chk("op0_alu_opcode", 32'(alu_opcode), 32'h33);
        chk("op0_alu_ast",    32'(alu_add_rshift_type), 1);
        chk("op0_alu_a",      alu_a, 10);
        chk("op0_alu_b",      alu_b, 3);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("op0_rsp_valid",  32'(rsp0_valid), 1);
        chk("op0_rsp_data",   rsp0_data, 7);
        chk("op0_idle_busy",  32'(busy), 0);
        tick();
        chk("op0_drained",    32'(rsp0_valid), 0);
        chk("op0_data_hold",  rsp0_data, 7);

        // tie test from a fresh reset: port 0 ADD 5+6=11, port 1 XORI 0x0F^0xFF=0xF0
        reset = 1'b1;
        #1;
        reset = 1'b0;
        set_req0(1, 7'b0110011, 3'b000, 0, 5, 6);
        set_req1(1, 7'b0010011, 3'b100, 0, 32'h0F, 32'hFF);
        prev_g = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
`ifdef ALU_ARB_RR_EN
            exp_g = k % 2;
`else
            exp_g = (k % 5 == 4) ? 1 : 0;
`endif
            chk($sformatf("tie_grant_%0d", k), 32'(grant_id), 32'(exp_g));
            chk($sformatf("tie_rdy0_%0d", k), 32'(req0_ready), 32'(exp_g == 0));
            chk($sformatf("tie_rdy1_%0d", k), 32'(req1_ready), 32'(exp_g == 1));
            if (k > 0) begin
                chk($sformatf("tie_rv0_%0d", k), 32'(rsp0_valid), 32'(prev_g == 0));
                chk($sformatf("tie_rv1_%0d", k), 32'(rsp1_valid), 32'(prev_g == 1));
                if (prev_g == 0) chk($sformatf("tie_rd0_%0d", k), rsp0_data, 11);
                else             chk($sformatf("tie_rd1_%0d", k), rsp1_data, 32'hF0);
            end
            prev_g = exp_g;
            tick();
        end

        // idle drive: fields still present but nothing valid
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("idle_busy",     32'(busy), 0);
        chk("idle_grant_id", 32'(grant_id), 0);
        chk("idle_opcode",   32'(alu_opcode), 0);
        chk("idle_funct",    32'(alu_funct), 0);
        chk("idle_ast",      32'(alu_add_rshift_type), 0);
        chk("idle_a",        alu_a, 0);
        chk("idle_b",        alu_b, 0);
        tick();

        // back-pressure on port 0
        rsp0_ready = 1'b0;
        set_req0(1, 7'b0110011, 3'b000, 0, 20, 22);
        #1;
        chk("bp_first_rdy0", 32'(req0_ready), 1);
        tick();
        set_req0(1, 7'b0110011, 3'b000, 1, 50, 5);
        set_req1(1, 7'b0010011, 3'b110, 0, 32'h30, 32'h03);
        #1;
        chk("bp_rsp0_valid", 32'(rsp0_valid), 1);
        chk("bp_rsp0_data",  rsp0_data, 42);
        chk("bp_rdy0",       32'(req0_ready), 0);
        chk("bp_rdy1",       32'(req1_ready), 1);
        chk("bp_grant_id",   32'(grant_id), 1);
        chk("bp_alu_a",      alu_a, 32'h30);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
        chk("bp_rsp1_data",  rsp1_data, 32'h33);
        chk("bp_rsp0_held",  32'(rsp0_valid), 1);
        chk("bp_data0_held", rsp0_data, 42);
        chk("bp_blk_rdy0",   32'(req0_ready), 0);
        chk("bp_blk_busy",   32'(busy), 0);
        rsp0_ready = 1'b1;
        #1;
        chk("bp_drain_rdy0", 32'(req0_ready), 1);
        chk("bp_drain_gid",  32'(grant_id), 0);
        chk("bp_drain_a",    alu_a, 50);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("bp_new_valid",  32'(rsp0_valid), 1);
        chk("bp_new_data",   rsp0_data, 45);
        chk("bp_rsp1_gone",  32'(rsp1_valid), 0);

        // reset mid-operation: rsp1 held full, port 0 grant in flight
        rsp1_ready = 1'b0;
        set_req1(1, 7'b0110011, 3'b111, 0, 32'hF0, 32'h3C);
        #1;
        chk("mr_rdy1",       32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        set_req0(1, 7'b0110011, 3'b000, 0, 1, 2);
        #1;
        chk("mr_rsp1_valid", 32'(rsp1_valid), 1);
        chk("mr_rsp1_data",  rsp1_data, 32'h30);
        chk("mr_rdy0",       32'(req0_ready), 1);
        reset = 1'b1;
        #1;
        chk("mr_async_rv1",  32'(rsp1_valid), 0);
        chk("mr_async_rd1",  rsp1_data, 0);
        chk("mr_async_rv0",  32'(rsp0_valid), 0);
        tick();
        req0_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("mr_post_rv0",   32'(rsp0_valid), 0);
        chk("mr_post_rv1",   32'(rsp1_valid), 0);
        tick();
        chk("mr_later_rv0",  32'(rsp0_valid), 0);
        chk("mr_later_rv1",  32'(rsp1_valid), 0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mr_tie_gid",    32'(grant_id), 0);
        chk("mr_tie_rdy0",   32'(req0_ready), 1);
        tick();
        chk("mr_tie_rv0",    32'(rsp0_valid), 1);
        chk("mr_tie_rd0",    rsp0_data, 3);
        chk("mr_tie_rv1",    32'(rsp1_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
